// File: rtl/addsub_seq_pkg.sv
// Shared types and constants for the multi-cycle adder-subtractor.
// Op encodings, FSM states and chunk-count helpers.
package addsub_seq_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-bit slices in a WIDTH-bit operand.
    function automatic int calc_n(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Width of the chunk index, never narrower than one bit.
    function automatic int calc_iw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple adder slice.
// One slice is reused every RUN cycle by the sequencer.
module addsub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    // Full add of the slice with carry-in, carry-out on the top bit.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle signed/unsigned adder-subtractor, CHUNK bits per cycle.
// Valid/ready on both sides, signed overflow, optional saturation.
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CHUNK  = 8,
    parameter int SAT_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry
);

    localparam int N  = calc_n(WIDTH, CHUNK);
    localparam int IW = calc_iw(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             cy;
    logic             a_msb;
    logic             b_msb;
    logic             sat_r;

    logic [CHUNK-1:0] sum;
    logic             c_out;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] sat_val;
    logic             ovf;
    logic             sat_hit;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .cin  (cy),
        .sum  (sum),
        .cout (c_out)
    );

    // Shift the new slice in from the top; flags use the final slice's MSB.
    always_comb begin
        res_next = WIDTH'({sum, res_sh} >> CHUNK);
        ovf      = (a_msb == b_msb) && (sum[CHUNK-1] != a_msb);
        sat_hit  = (SAT_EN != 0) && sat_r && ovf;
        sat_val  = a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                         : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // Control FSM with operand/result shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            carry     <= 1'b0;
            idx       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            cy        <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            sat_r     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= a;
                        b_sh     <= b ^ {WIDTH{op}};
                        cy       <= op;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1] ^ op;
                        sat_r    <= sat;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> CHUNK;
                    b_sh   <= b_sh >> CHUNK;
                    res_sh <= res_next;
                    cy     <= c_out;
                    idx    <= idx + 1'b1;
                    if (idx == LAST) begin
                        idx       <= '0;
                        carry     <= c_out;
                        overflow  <= ovf;
                        result    <= sat_hit ? sat_val : res_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// Directed and swept checks for addsub_seq.
// 32-bit default instance plus three 16-bit chunkings.
module tb_addsub_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        carry;

    logic        s_valid;
    logic [15:0] s_a;
    logic [15:0] s_b;
    logic        s_op;
    logic        s_sat;
    logic        s_ready;
    logic [2:0]  sw_iready;
    logic [2:0]  sw_ovalid;
    logic [2:0]  sw_ov;
    logic [2:0]  sw_cy;
    logic [15:0] sw_res [3];

    int applied = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    addsub_seq dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .carry(carry)
    );

    addsub_seq #(.WIDTH(16), .CHUNK(16), .SAT_EN(1)) dut_c16 (
        .clk(clk), .reset(reset),
        .in_valid(s_valid), .in_ready(sw_iready[0]),
        .a(s_a), .b(s_b), .op(s_op), .sat(s_sat),
        .out_valid(sw_ovalid[0]), .out_ready(s_ready),
        .result(sw_res[0]), .overflow(sw_ov[0]), .carry(sw_cy[0])
    );

    addsub_seq #(.WIDTH(16), .CHUNK(4), .SAT_EN(1)) dut_c4 (
        .clk(clk), .reset(reset),
        .in_valid(s_valid), .in_ready(sw_iready[1]),
        .a(s_a), .b(s_b), .op(s_op), .sat(s_sat),
        .out_valid(sw_ovalid[1]), .out_ready(s_ready),
        .result(sw_res[1]), .overflow(sw_ov[1]), .carry(sw_cy[1])
    );

    addsub_seq #(.WIDTH(16), .CHUNK(1), .SAT_EN(1)) dut_c1 (
        .clk(clk), .reset(reset),
        .in_valid(s_valid), .in_ready(sw_iready[2]),
        .a(s_a), .b(s_b), .op(s_op), .sat(s_sat),
        .out_valid(sw_ovalid[2]), .out_ready(s_ready),
        .result(sw_res[2]), .overflow(sw_ov[2]), .carry(sw_cy[2])
    );

    // Wait for out_valid from the negedge after the accept edge.
    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
    endtask

    // One full transaction on the 32-bit instance with a handshake.
    task automatic run_op(
        input  logic [31:0] ta, input logic [31:0] tb,
        input  logic top, input logic tsat,
        output logic [31:0] r, output logic ov, output logic cy,
        output int lat
    );
        in_valid = 1'b1;
        a = ta; b = tb; op = top; sat = tsat;
        @(negedge clk);
        in_valid = 1'b0;
        a = 32'hDEADBEEF; b = 32'h12345678; op = ~top; sat = ~tsat;
        wait_valid(lat);
        r = result; ov = overflow; cy = carry;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_op(
        input string name,
        input logic [31:0] ta, input logic [31:0] tb,
        input logic top, input logic tsat,
        input logic [31:0] er, input logic eov, input logic ecy
    );
        logic [31:0] r;
        logic ov, cy;
        int lat;
        run_op(ta, tb, top, tsat, r, ov, cy, lat);
        applied++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL %s latency: got %0d want 4", name, lat);
        end
        applied++;
        if (r !== er) begin
            miscompares++;
            $display("FAIL %s result: got %h want %h", name, r, er);
        end
        applied++;
        if (ov !== eov) begin
            miscompares++;
            $display("FAIL %s overflow: got %b want %b", name, ov, eov);
        end
        applied++;
        if (cy !== ecy) begin
            miscompares++;
            $display("FAIL %s carry: got %b want %b", name, cy, ecy);
        end
        applied++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s idle_after: got v=%b r=%b want v=0 r=1",
                     name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        applied++;
        if ({in_ready, out_valid, overflow, carry} !== 4'b1000
            || result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset: got rdy=%b v=%b ov=%b cy=%b res=%h want 1 0 0 0 0",
                     in_ready, out_valid, overflow, carry, result);
        end
        applied++;
        if (sw_iready !== 3'b111 || sw_ovalid !== 3'b000) begin
            miscompares++;
            $display("FAIL reset16: got rdy=%b v=%b want 111 000",
                     sw_iready, sw_ovalid);
        end
    endtask

    task automatic test_arith();
        check_op("sub_basic", 32'd222222, 32'd200000, 1'b1, 1'b0,
                 32'h000056CE, 1'b0, 1'b1);
        check_op("sub_ovf", 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b0,
                 32'h00000001, 1'b1, 1'b1);
        check_op("sub_ovf_sat", 32'h80000000, 32'h7FFFFFFF, 1'b1, 1'b1,
                 32'h80000000, 1'b1, 1'b1);
        check_op("sub_borrow", 32'd1, 32'd2, 1'b1, 1'b0,
                 32'hFFFFFFFF, 1'b0, 1'b0);
        check_op("add_ovf_sat", 32'h7FFFFFFF, 32'd1, 1'b0, 1'b1,
                 32'h7FFFFFFF, 1'b1, 1'b0);
        check_op("add_carry", 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0,
                 32'h00000001, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        int lat;
        in_valid = 1'b1;
        a = 32'd5; b = 32'd7; op = 1'b0; sat = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        in_valid = 1'b1;
        a = 32'd3; b = 32'd4; op = 1'b0; sat = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applied++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0
                || result !== 32'd12 || overflow !== 1'b0
                || carry !== 1'b0) begin
                miscompares++;
                $display("FAIL hold%0d: got v=%b rdy=%b res=%h ov=%b cy=%b want 1 0 c 0 0",
                         i, out_valid, in_ready, result, overflow, carry);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        applied++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release: got v=%b rdy=%b want 0 1",
                     out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a = '0; b = '0;
        wait_valid(lat);
        applied++;
        if (lat !== 4 || result !== 32'd7) begin
            miscompares++;
            $display("FAIL pending: got lat=%0d res=%h want 4 7", lat, result);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat;
        int hi;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 32'd10; b = 32'd3; op = 1'b1; sat = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        applied++;
        if (result !== 32'd7 || carry !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_res: got %h cy=%b want 7 1", result, carry);
        end
        hi = 0;
        while (out_valid && hi < 10) begin
            hi++;
            @(negedge clk);
        end
        applied++;
        if (hi !== 1) begin
            miscompares++;
            $display("FAIL b2b_pulse: got %0d cycles want 1", hi);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        in_valid = 1'b1;
        a = 32'd9; b = 32'd9; op = 1'b0; sat = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        applied++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset: got rdy=%b v=%b res=%h want 1 0 0",
                     in_ready, out_valid, result);
        end
        check_op("after_reset", 32'd100000000, 32'd200000000, 1'b1, 1'b0,
                 32'hFA0A1F00, 1'b0, 1'b0);
    endtask

    task automatic ref16(
        input logic [15:0] ta, input logic [15:0] tb,
        input logic top, input logic tsat,
        output logic [15:0] r, output logic ov, output logic cy
    );
        logic [16:0] full;
        int sa, sb, s;
        sa = int'($signed(ta));
        sb = int'($signed(tb));
        if (top) begin
            full = {1'b0, ta} - {1'b0, tb};
            cy = (ta >= tb);
            s = sa - sb;
        end else begin
            full = {1'b0, ta} + {1'b0, tb};
            cy = full[16];
            s = sa + sb;
        end
        ov = (s > 32767) || (s < -32768);
        r = full[15:0];
        if (tsat && ov)
            r = (s > 0) ? 16'h7FFF : 16'h8000;
    endtask

    task automatic test_sweep();
        logic [15:0] er;
        logic eov, ecy;
        int lat [3];
        int cnt;
        int want [3];
        want[0] = 1; want[1] = 4; want[2] = 16;
        for (int t = 0; t < 1000; t++) begin
            s_a = 16'($urandom);
            s_b = 16'($urandom);
            s_op = 1'($urandom);
            s_sat = 1'($urandom);
            if (t < 4) begin
                s_a = (t[0]) ? 16'h8000 : 16'h7FFF;
                s_b = (t[0]) ? 16'h0001 : 16'h0001;
                s_op = t[0];
            end
            ref16(s_a, s_b, s_op, s_sat, er, eov, ecy);
            s_valid = 1'b1;
            @(negedge clk);
            s_valid = 1'b0;
            s_a = 16'($urandom);
            s_b = 16'($urandom);
            s_op = ~s_op;
            s_sat = ~s_sat;
            for (int k = 0; k < 3; k++) lat[k] = 0;
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
                for (int k = 0; k < 3; k++)
                    if (sw_ovalid[k] && lat[k] == 0) lat[k] = cnt;
            end while (sw_ovalid !== 3'b111 && cnt < 40);
            for (int k = 0; k < 3; k++) begin
                applied++;
                if (lat[k] !== want[k]) begin
                    miscompares++;
                    $display("FAIL sweep%0d_c%0d lat: got %0d want %0d",
                             t, k, lat[k], want[k]);
                end
                applied++;
                if (sw_res[k] !== er) begin
                    miscompares++;
                    $display("FAIL sweep%0d_c%0d res: got %h want %h",
                             t, k, sw_res[k], er);
                end
                applied++;
                if (sw_ov[k] !== eov) begin
                    miscompares++;
                    $display("FAIL sweep%0d_c%0d ov: got %b want %b",
                             t, k, sw_ov[k], eov);
                end
                applied++;
                if (sw_cy[k] !== ecy) begin
                    miscompares++;
                    $display("FAIL sweep%0d_c%0d cy: got %b want %b",
                             t, k, sw_cy[k], ecy);
                end
            end
            s_ready = 1'b1;
            @(negedge clk);
            s_ready = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; op = 1'b0; sat = 1'b0;
        out_ready = 1'b0;
        s_valid = 1'b0; s_a = '0; s_b = '0; s_op = 1'b0; s_sat = 1'b0;
        s_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised multi-cycle signed/unsigned adder-subtractor for the MiniMIPS datapath; successor to the combinational 32-bit subtractor.
- Processes CHUNK bits per clock through a ripple chunk adder, so wide operands meet timing.
- Adds an add/sub mode, unsigned carry/borrow, signed overflow, optional saturation, and a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per RUN cycle; N = WIDTH/CHUNK.
- SAT_EN, 1, 1 = saturation hardware present; 0 = sat input ignored.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode valid.
- in_ready  out  1  block can accept a request (high only in IDLE).
- a  in  WIDTH  operand A (two's complement when read as signed).
- b  in  WIDTH  operand B.
- op  in  1  0 = A+B, 1 = A-B.
- sat  in  1  saturate signed result on overflow (effective only if SAT_EN=1).
- out_valid  out  1  result fields valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum/difference, saturated if enabled.
- overflow  out  1  signed overflow of the unsaturated operation.
- carry  out  1  unsigned carry-out; for subtraction, 1 = no borrow.

Behaviour:
- Reset, synchronous and active-high: state=IDLE; in_ready=1; out_valid=0; result=0; overflow=0; carry=0; internal chunk index=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch a, b^{WIDTH{op}}, carry-in=op, op and sat; go to RUN.
  - RUN: each cycle add chunk[idx] of A and B' plus the running carry; write the CHUNK result bits; idx++. After chunk N-1, go to DONE.
  - DONE: out_valid=1; outputs stable. On out_ready, go to IDLE and clear out_valid.
- Latency:
  - Request accepted at edge E; out_valid is first high after edge E+N (N=4 with defaults).
  - Best-case throughput is one request per N+2 cycles (no simultaneous accept in DONE).
- Arithmetic:
  - carry = carry-out of the MSB chunk.
  - overflow = (A[MSB] == B'[MSB]) && (raw[MSB] != A[MSB]).
  - If SAT_EN && sat && overflow: result = A[MSB] ? 1 followed by zeros (most negative) : 0 followed by ones (most positive). overflow and carry still report the raw operation.
  - Otherwise result = raw sum mod 2^WIDTH.
- Boundary conditions:
  - in_valid outside IDLE is ignored; operands are never re-sampled mid-operation.
  - out_ready outside DONE is ignored.
  - out_ready held high while entering DONE: out_valid is high for exactly one cycle.
  - Reset at any point, including mid-RUN or DONE, overrides everything: next cycle is IDLE with reset values, and the partial result is discarded.
  - CHUNK == WIDTH is legal: one RUN cycle, N=1.
  - Operand bus values outside the accept cycle have no effect.

Decomposition:
- Shared package:
  - op encodings OP_ADD=0, OP_SUB=1;
  - state enum IDLE/RUN/DONE (2 bits);
  - helper constant function for N and index width clog2(N), minimum 1.
- One sub-module: addsub_chunk, a combinational CHUNK-bit adder taking a, b, cin and returning sum and cout. The top level owns the FSM, operand/result shift registers and flag logic.

Test Plan:
- op=1, a=222222, b=200000, sat=0 -> after 4 cycles result=22222 (0x000056CE), overflow=0, carry=1.
- op=1, a=0x80000000, b=0x7FFFFFFF, sat=0 -> result=0x00000001, overflow=1, carry=1. Repeat with sat=1 -> result=0x80000000, overflow=1.
- op=1, a=1, b=2 -> result=0xFFFFFFFF (-1), overflow=0, carry=0 (borrow). Then op=0, a=0x7FFFFFFF, b=1, sat=1 -> result=0x7FFFFFFF, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> result and flags stable, in_ready=0, a second in_valid is ignored. Raise out_ready -> one-cycle handshake, then IDLE accepts the pending request.
- Reset asserted in the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, result=0. A following request with a=100000000, b=200000000, op=1 yields result=-100000000 (0xFA0A1F00), carry=0.
- Parameter sweep: WIDTH=16 with CHUNK=16, 4 and 1 against a reference model over 1000 random operands/modes. Latency must equal WIDTH/CHUNK, and all three outputs must match.
